// File: rtl/event_kernel_scanner.sv
// Scans the KERNEL_SIZE x KERNEL_SIZE neighbourhood of each accepted spike event, emitting in-bounds window beats.
// Optional KERNEL_SCAN_STATS_EN adds stat_events/stat_windows counters.
module event_kernel_scanner #(
    parameter int IMG_WIDTH           = 32,
    parameter int IMG_HEIGHT          = 32,
    parameter int BITS_PER_COORDINATE = 8,
    parameter int IN_CHANNELS         = 4,
    parameter int KERNEL_SIZE         = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             event_valid,
    input  logic [BITS_PER_COORDINATE-1:0]   event_x,
    input  logic [BITS_PER_COORDINATE-1:0]   event_y,
    input  logic [IN_CHANNELS-1:0]           event_spikes,
    output logic                             conv_ready,
    output logic                             conv_ack,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [BITS_PER_COORDINATE-1:0]   win_x,
    output logic [BITS_PER_COORDINATE-1:0]   win_y,
    output logic [$clog2(KERNEL_SIZE):0]     win_kx,
    output logic [$clog2(KERNEL_SIZE):0]     win_ky,
    output logic [IN_CHANNELS-1:0]           win_spikes,
    output logic                             win_last
`ifdef KERNEL_SCAN_STATS_EN
    ,
    output logic [31:0]                      stat_events,
    output logic [31:0]                      stat_windows
`endif
);

    localparam int KW = $clog2(KERNEL_SIZE) + 1;
    localparam int SW = BITS_PER_COORDINATE + 2;
    localparam int C  = KERNEL_SIZE / 2;
    localparam logic [KW-1:0] KMAX  = KW'(KERNEL_SIZE - 1);
    localparam logic [SW-1:0] W_LIM = SW'(IMG_WIDTH);
    localparam logic [SW-1:0] H_LIM = SW'(IMG_HEIGHT);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                         state_q, state_d;
    logic [BITS_PER_COORDINATE-1:0] x_q, y_q;
    logic [IN_CHANNELS-1:0]         spikes_q;
    logic [KW-1:0]                  kx_q, ky_q, kx_d, ky_d;
    logic                           ack_q;
    logic [SW-1:0]                  px, py;
    logic                           in_bounds, advance, accept, last_pos;
    logic                           col_after, row_after;

    // Position is signed (MSB = sign) so taps left/above the image read as negative.
    function automatic logic tap_ok(input logic [BITS_PER_COORDINATE-1:0] base,
                                    input logic [KW-1:0] k,
                                    input logic [SW-1:0] lim);
        logic [SW-1:0] p;
        p = {2'b00, base} + SW'(k) - SW'(C);
        return !p[SW-1] && (p < lim);
    endfunction

    assign accept   = (state_q == IDLE) && event_valid;
    assign px       = {2'b00, x_q} + SW'(kx_q) - SW'(C);
    assign py       = {2'b00, y_q} + SW'(ky_q) - SW'(C);
    assign in_bounds = tap_ok(x_q, kx_q, W_LIM) && tap_ok(y_q, ky_q, H_LIM);
    assign advance  = (state_q == SCAN) && (!in_bounds || win_ready);
    assign last_pos = (kx_q == KMAX) && (ky_q == KMAX);

    // A beat is last when no later tap in this row, nor any later row, lands in bounds.
    always_comb begin
        col_after = 1'b0;
        row_after = 1'b0;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
            if (KW'(i) > kx_q && tap_ok(x_q, KW'(i), W_LIM)) col_after = 1'b1;
            if (KW'(i) > ky_q && tap_ok(y_q, KW'(i), H_LIM)) row_after = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        case (state_q)
            IDLE: begin
                if (event_valid) begin
                    state_d = SCAN;
                    kx_d    = '0;
                    ky_d    = '0;
                end
            end
            SCAN: begin
                if (advance) begin
                    if (last_pos) begin
                        state_d = IDLE;
                        kx_d    = '0;
                        ky_d    = '0;
                    end else if (kx_q == KMAX) begin
                        kx_d = '0;
                        ky_d = ky_q + 1'b1;
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kx_q     <= '0;
            ky_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            spikes_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            ack_q   <= accept;
            if (accept) begin
                x_q      <= event_x;
                y_q      <= event_y;
                spikes_q <= event_spikes;
            end
        end
    end

    assign conv_ready = (state_q == IDLE);
    assign conv_ack   = ack_q;
    assign win_valid  = (state_q == SCAN) && in_bounds;
    assign win_last   = win_valid && !col_after && !row_after;
    assign win_x      = win_valid ? px[BITS_PER_COORDINATE-1:0] : '0;
    assign win_y      = win_valid ? py[BITS_PER_COORDINATE-1:0] : '0;
    assign win_kx     = win_valid ? kx_q : '0;
    assign win_ky     = win_valid ? ky_q : '0;
    assign win_spikes = win_valid ? spikes_q : '0;

`ifdef KERNEL_SCAN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_events  <= '0;
            stat_windows <= '0;
        end else begin
            if (accept)                 stat_events  <= stat_events + 32'd1;
            if (win_valid && win_ready) stat_windows <= stat_windows + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_event_kernel_scanner.sv
// Self-checking bench for event_kernel_scanner: randomized events and stalls against a queue-based window model.
module tb_event_kernel_scanner;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int B  = 8;
    localparam int CH = 4;
    localparam int K  = 3;
    localparam int KW = $clog2(K) + 1;
    localparam int C  = K / 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          event_valid;
    logic [B-1:0]  event_x, event_y;
    logic [CH-1:0] event_spikes;
    logic          conv_ready, conv_ack, win_valid, win_ready, win_last;
    logic [B-1:0]  win_x, win_y;
    logic [KW-1:0] win_kx, win_ky;
    logic [CH-1:0] win_spikes;
`ifdef KERNEL_SCAN_STATS_EN
    logic [31:0]   stat_events, stat_windows;
`endif

    typedef struct {int x; int y; int kx; int ky;} beat_t;
    beat_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int exp_events = 0;
    int exp_windows = 0;

    always #5 clk = ~clk;

    event_kernel_scanner #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .BITS_PER_COORDINATE(B),
        .IN_CHANNELS(CH), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .event_valid(event_valid), .event_x(event_x), .event_y(event_y),
        .event_spikes(event_spikes),
        .conv_ready(conv_ready), .conv_ack(conv_ack),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_x(win_x), .win_y(win_y), .win_kx(win_kx), .win_ky(win_ky),
        .win_spikes(win_spikes), .win_last(win_last)
`ifdef KERNEL_SCAN_STATS_EN
        , .stat_events(stat_events), .stat_windows(stat_windows)
`endif
    );

    // Expected beats: every tap of the neighbourhood, row-major, kept only if inside the image.
    task automatic build_expected(input int ex, input int ey);
        exp_q.delete();
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
                int px, py;
                px = ex + kx - C;
                py = ey + ky - C;
                if (px >= 0 && px < W && py >= 0 && py < H) exp_q.push_back('{px, py, kx, ky});
            end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (conv_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (conv_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_timeout: conv_ready=%b want 1", tag, conv_ready);
        end
    endtask

    task automatic run_event(input string tag, input int ex, input int ey, input logic [CH-1:0] spk,
                             input int stall_beat, input int stall_len, input bit rnd);
        int idx, cycles, stalls, left;
        logic exp_last;
        beat_t b;
        wait_idle(tag);
        build_expected(ex, ey);
        event_x = B'(ex);
        event_y = B'(ey);
        event_spikes = spk;
        event_valid = 1'b1;
        win_ready = 1'b1;
        @(posedge clk); #1;
        event_valid = 1'b0;
        checks++;
        if (conv_ack !== 1'b1 || conv_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: ack=%b ready=%b want ack=1 ready=0", tag, conv_ack, conv_ready);
        end
        idx = 0; cycles = 0; stalls = 0; left = stall_len;
        while (conv_ready !== 1'b1 && cycles < 200) begin
            cycles++;
            if (cycles > 1) begin
                checks++;
                if (conv_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL %s ack_pulse cyc%0d: ack=%b want 0", tag, cycles, conv_ack);
                end
            end
            if (win_valid === 1'b1) begin
                checks++;
                if (idx >= exp_q.size()) begin
                    failures++;
                    $display("FAIL %s extra_beat: got (%0d,%0d) beat%0d, model has %0d beats",
                             tag, win_x, win_y, idx, exp_q.size());
                end else begin
                    b = exp_q[idx];
                    exp_last = (idx == exp_q.size() - 1);
                    if (win_x !== B'(b.x) || win_y !== B'(b.y) || win_kx !== KW'(b.kx) ||
                        win_ky !== KW'(b.ky) || win_spikes !== spk || win_last !== exp_last) begin
                        failures++;
                        $display("FAIL %s beat%0d: got x=%0d y=%0d kx=%0d ky=%0d spk=%b last=%b want x=%0d y=%0d kx=%0d ky=%0d spk=%b last=%b",
                                 tag, idx, win_x, win_y, win_kx, win_ky, win_spikes, win_last,
                                 b.x, b.y, b.kx, b.ky, spk, exp_last);
                    end
                end
                if (idx == stall_beat && left > 0) begin
                    win_ready = 1'b0;
                    left--;
                end else begin
                    win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (win_ready) idx++;
                else stalls++;
            end else begin
                checks++;
                if (win_last !== 1'b0) begin
                    failures++;
                    $display("FAIL %s last_without_valid: win_last=%b want 0", tag, win_last);
                end
                win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #1;
        end
        win_ready = 1'b1;
        checks++;
        if (idx != exp_q.size()) begin
            failures++;
            $display("FAIL %s beat_count: got %0d want %0d", tag, idx, exp_q.size());
        end
        checks++;
        if (cycles != K * K + stalls) begin
            failures++;
            $display("FAIL %s scan_cycles: got %0d want %0d", tag, cycles, K * K + stalls);
        end
        exp_events++;
        exp_windows += exp_q.size();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        event_valid = 1'b0;
        event_x = '0; event_y = '0; event_spikes = '0;
        win_ready = 1'b1;
        #13;
        checks++;
        if (conv_ready !== 1'b1 || conv_ack !== 1'b0 || win_valid !== 1'b0 || win_last !== 1'b0 ||
            win_x !== '0 || win_y !== '0 || win_kx !== '0 || win_ky !== '0 || win_spikes !== '0) begin
            failures++;
            $display("FAIL reset_state: ready=%b ack=%b valid=%b last=%b x=%0d y=%0d kx=%0d ky=%0d spk=%b want 1 0 0 0 0 0 0 0 0",
                     conv_ready, conv_ack, win_valid, win_last, win_x, win_y, win_kx, win_ky, win_spikes);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_events = 0;
        exp_windows = 0;
    endtask

    task automatic test_corners;
        run_event("centre_5_5", 5, 5, 4'b1010, -1, 0, 1'b0);
        run_event("corner_0_0", 0, 0, 4'b1010, -1, 0, 1'b0);
        run_event("corner_31_31", 31, 31, 4'b1010, -1, 0, 1'b0);
        run_event("edge_0_31", 0, 31, 4'b0110, -1, 0, 1'b0);
        run_event("outside_200", 200, 7, 4'b0001, -1, 0, 1'b0);
        run_event("zero_spikes", 12, 3, 4'b0000, -1, 0, 1'b0);
    endtask

    task automatic test_stall;
        run_event("stall_beat2", 5, 5, 4'b1010, 1, 3, 1'b0);
        run_event("stall_last", 31, 0, 4'b1111, 3, 2, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int ex, ey;
            ex = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 255) : $urandom_range(0, 33);
            ey = $urandom_range(0, 33);
            run_event("random", ex, ey, CH'($urandom), -1, 0, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        int period, nbeats;
        wait_idle("hold");
        build_expected(5, 5);
        nbeats = exp_q.size();
        period = K * K + 1;
        event_x = 8'd5; event_y = 8'd5; event_spikes = 4'b0101;
        win_ready = 1'b1;
        event_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (conv_ack !== ((i % period) == 0)) begin
                failures++;
                $display("FAIL hold_ack cyc%0d: ack=%b want %b", i, conv_ack, (i % period) == 0);
            end
        end
        event_valid = 1'b0;
        exp_events += (20 + period - 1) / period;
        exp_windows += nbeats * ((20 + period - 1) / period);
    endtask

    task automatic test_reset_mid_scan;
        int n;
        wait_idle("reset_mid");
        event_x = 8'd5; event_y = 8'd5; event_spikes = 4'b1001;
        win_ready = 1'b1;
        event_valid = 1'b1;
        @(posedge clk); #1;
        event_valid = 1'b0;
        n = 0;
        while (n < 4 && conv_ready !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (win_valid !== 1'b1 || win_kx !== KW'(1) || win_ky !== KW'(1)) begin
            failures++;
            $display("FAIL reset_mid_beat5: valid=%b kx=%0d ky=%0d want 1 1 1", win_valid, win_kx, win_ky);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (win_valid !== 1'b0 || conv_ready !== 1'b1 || conv_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: valid=%b ready=%b ack=%b want 0 1 0", win_valid, conv_ready, conv_ack);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_events = 0;
        exp_windows = 0;
        @(posedge clk); #1;
        run_event("after_reset", 10, 10, 4'b0011, -1, 0, 1'b0);
    endtask

`ifdef KERNEL_SCAN_STATS_EN
    task automatic test_stats;
        test_reset;
        run_event("stats_5_5", 5, 5, 4'b1010, -1, 0, 1'b0);
        run_event("stats_0_0", 0, 0, 4'b1010, -1, 0, 1'b0);
        checks++;
        if (stat_events !== 32'(exp_events) || stat_windows !== 32'(exp_windows)) begin
            failures++;
            $display("FAIL stats: events=%0d windows=%0d want %0d %0d",
                     stat_events, stat_windows, exp_events, exp_windows);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_corners;
        test_stall;
        test_random;
        test_back_to_back;
        test_reset_mid_scan;
`ifdef KERNEL_SCAN_STATS_EN
        test_stats;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
